idu_is_pipe2_sched: RTL

Out-of-order issue scheduler for execution pipe 2. Holds dispatched instructions until their physical source operands are produced, then issues the oldest ready one per cycle into the pipe-2 register-read stage through the `idu_idu_rf_pipe2_*` bus. Wakeup comes from the ALU/MXU/DIV/LSU EX-stage preg broadcasts. Sits between dispatch and the pipe-2 RF stage, which performs the final operand forwarding.

---
 rtl/idu_is_pipe2_sched_if.sv | 64 ++++++
 rtl/idu_is_pipe2_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/idu_is_pipe2_sched_if.sv
// Dispatch request and pipe-2 RF issue bus of the pipe-2 issue scheduler.
// The slave modport is the scheduler's view; the master modport is the dispatcher and RF-stage view.
interface idu_is_pipe2_sched_if;
    logic        dis_vld;
    logic        dis_rdy;
    logic [3:0]  dis_iid;
    logic [6:0]  dis_opcode;
    logic [6:0]  dis_funct7;
    logic [2:0]  dis_funct3;
    logic [63:0] dis_pc;
    logic        dis_psrc1_vld;
    logic [5:0]  dis_psrc1;
    logic        dis_psrc1_rdy;
    logic        dis_psrc2_vld;
    logic [5:0]  dis_psrc2;
    logic        dis_psrc2_rdy;
    logic        dis_pdst_vld;
    logic [5:0]  dis_pdst;
    logic        dis_imm_vld;
    logic [63:0] dis_imm;

    logic        idu_idu_rf_pipe2_vld;
    logic [3:0]  idu_idu_rf_pipe2_iid;
    logic [6:0]  idu_idu_rf_pipe2_opcode;
    logic [6:0]  idu_idu_rf_pipe2_funct7;
    logic [2:0]  idu_idu_rf_pipe2_funct3;
    logic [63:0] idu_idu_rf_pipe2_pc;
    logic        idu_idu_rf_pipe2_psrc1_vld;
    logic [5:0]  idu_idu_rf_pipe2_psrc1;
    logic        idu_idu_rf_pipe2_psrc2_vld;
    logic [5:0]  idu_idu_rf_pipe2_psrc2;
    logic        idu_idu_rf_pipe2_pdst_vld;
    logic [5:0]  idu_idu_rf_pipe2_pdst;
    logic        idu_idu_rf_pipe2_imm_vld;
    logic [63:0] idu_idu_rf_pipe2_imm;

    modport master (
        output dis_vld, dis_iid, dis_opcode, dis_funct7, dis_funct3, dis_pc,
               dis_psrc1_vld, dis_psrc1, dis_psrc1_rdy,
               dis_psrc2_vld, dis_psrc2, dis_psrc2_rdy,
               dis_pdst_vld, dis_pdst, dis_imm_vld, dis_imm,
        input  dis_rdy,
               idu_idu_rf_pipe2_vld, idu_idu_rf_pipe2_iid, idu_idu_rf_pipe2_opcode,
               idu_idu_rf_pipe2_funct7, idu_idu_rf_pipe2_funct3, idu_idu_rf_pipe2_pc,
               idu_idu_rf_pipe2_psrc1_vld, idu_idu_rf_pipe2_psrc1,
               idu_idu_rf_pipe2_psrc2_vld, idu_idu_rf_pipe2_psrc2,
               idu_idu_rf_pipe2_pdst_vld, idu_idu_rf_pipe2_pdst,
               idu_idu_rf_pipe2_imm_vld, idu_idu_rf_pipe2_imm
    );

    modport slave (
        input  dis_vld, dis_iid, dis_opcode, dis_funct7, dis_funct3, dis_pc,
               dis_psrc1_vld, dis_psrc1, dis_psrc1_rdy,
               dis_psrc2_vld, dis_psrc2, dis_psrc2_rdy,
               dis_pdst_vld, dis_pdst, dis_imm_vld, dis_imm,
        output dis_rdy,
               idu_idu_rf_pipe2_vld, idu_idu_rf_pipe2_iid, idu_idu_rf_pipe2_opcode,
               idu_idu_rf_pipe2_funct7, idu_idu_rf_pipe2_funct3, idu_idu_rf_pipe2_pc,
               idu_idu_rf_pipe2_psrc1_vld, idu_idu_rf_pipe2_psrc1,
               idu_idu_rf_pipe2_psrc2_vld, idu_idu_rf_pipe2_psrc2,
               idu_idu_rf_pipe2_pdst_vld, idu_idu_rf_pipe2_pdst,
               idu_idu_rf_pipe2_imm_vld, idu_idu_rf_pipe2_imm
    );
endinterface

// File: rtl/idu_is_pipe2_sched.sv
// Pipe-2 out-of-order issue queue: wakeup from EX preg broadcasts, oldest-ready select via age matrix.
// Optional same-cycle empty-queue bypass issue is enabled by defining IDU_IS_PIPE2_BYPASS_EN.
module idu_is_pipe2_sched #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_clk,
    input  logic       rtu_global_flush,
    idu_is_pipe2_sched_if.slave sched,
    input  logic       exu_idu_is_alu_ex_vld,
    input  logic [5:0] exu_idu_is_alu_ex_preg,
    input  logic       exu_idu_is_mxu_ex_vld,
    input  logic [5:0] exu_idu_is_mxu_ex_preg,
    input  logic       exu_idu_is_div_ex_vld,
    input  logic [5:0] exu_idu_is_div_ex_preg,
    input  logic       exu_idu_is_lsu_ex_vld,
    input  logic [5:0] exu_idu_is_lsu_ex_preg,
    input  logic       exu_idu_is_pipe2_stall
);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, s1r_q, s2r_q, s1v_q, s2v_q, pdv_q, immv_q;
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [3:0]       iid_q [DEPTH];
    logic [6:0]       opc_q [DEPTH];
    logic [6:0]       f7_q  [DEPTH];
    logic [2:0]       f3_q  [DEPTH];
    logic [63:0]      pc_q  [DEPTH];
    logic [5:0]       s1_q  [DEPTH];
    logic [5:0]       s2_q  [DEPTH];
    logic [5:0]       pd_q  [DEPTH];
    logic [63:0]      imm_q [DEPTH];

    logic [DEPTH-1:0] ready, sel_oh, issue_oh;
    logic [IW-1:0]    sel_idx, free_idx;
    logic             free_found, full, empty, issue_go, alloc, cap1, cap2, bypass_go;

    function automatic logic bc_hit(input logic [5:0] p);
        return (exu_idu_is_alu_ex_vld && exu_idu_is_alu_ex_preg == p) ||
               (exu_idu_is_mxu_ex_vld && exu_idu_is_mxu_ex_preg == p) ||
               (exu_idu_is_div_ex_vld && exu_idu_is_div_ex_preg == p) ||
               (exu_idu_is_lsu_ex_vld && exu_idu_is_lsu_ex_preg == p);
    endfunction

    always_comb begin
        ready      = valid_q & s1r_q & s2r_q;
        sel_oh     = '0;
        sel_idx    = '0;
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // An entry wins only if no entry it considers older is also ready.
            sel_oh[i] = ready[i] && !(|(age_q[i] & ready));
            if (sel_oh[i]) sel_idx = i[IW-1:0];
            if (!valid_q[i] && !free_found) begin
                free_idx   = i[IW-1:0];
                free_found = 1'b1;
            end
        end
        full     = &valid_q;
        empty    = ~|valid_q;
        issue_go = (|ready) && !exu_idu_is_pipe2_stall && !rtu_global_flush;
        issue_oh = issue_go ? sel_oh : '0;
        cap1     = !sched.dis_psrc1_vld || sched.dis_psrc1_rdy || bc_hit(sched.dis_psrc1);
        cap2     = !sched.dis_psrc2_vld || sched.dis_psrc2_rdy || bc_hit(sched.dis_psrc2);
`ifdef IDU_IS_PIPE2_BYPASS_EN
        bypass_go = empty && sched.dis_vld && cap1 && cap2 &&
                    !exu_idu_is_pipe2_stall && !rtu_global_flush;
`else
        bypass_go = 1'b0;
`endif
        alloc = sched.dis_vld && !full && !rtu_global_flush && !bypass_go;
    end

    assign sched.dis_rdy = !full;

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            valid_q <= '0;
            s1r_q   <= '0;
            s2r_q   <= '0;
            s1v_q   <= '0;
            s2v_q   <= '0;
            pdv_q   <= '0;
            immv_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
                iid_q[i] <= '0;
                opc_q[i] <= '0;
                f7_q[i]  <= '0;
                f3_q[i]  <= '0;
                pc_q[i]  <= '0;
                s1_q[i]  <= '0;
                s2_q[i]  <= '0;
                pd_q[i]  <= '0;
                imm_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (s1v_q[i] && bc_hit(s1_q[i])) s1r_q[i] <= 1'b1;
                if (s2v_q[i] && bc_hit(s2_q[i])) s2r_q[i] <= 1'b1;
                age_q[i] <= age_q[i] & ~issue_oh;
            end
            if (rtu_global_flush) begin
                valid_q <= '0;
            end else begin
                valid_q <= valid_q & ~issue_oh;
                // Written last so the new entry's fields and age row override the updates above.
                if (alloc) begin
                    valid_q[free_idx] <= 1'b1;
                    age_q[free_idx]   <= valid_q & ~issue_oh;
                    s1r_q[free_idx]   <= cap1;
                    s2r_q[free_idx]   <= cap2;
                    s1v_q[free_idx]   <= sched.dis_psrc1_vld;
                    s2v_q[free_idx]   <= sched.dis_psrc2_vld;
                    pdv_q[free_idx]   <= sched.dis_pdst_vld;
                    immv_q[free_idx]  <= sched.dis_imm_vld;
                    iid_q[free_idx]   <= sched.dis_iid;
                    opc_q[free_idx]   <= sched.dis_opcode;
                    f7_q[free_idx]    <= sched.dis_funct7;
                    f3_q[free_idx]    <= sched.dis_funct3;
                    pc_q[free_idx]    <= sched.dis_pc;
                    s1_q[free_idx]    <= sched.dis_psrc1;
                    s2_q[free_idx]    <= sched.dis_psrc2;
                    pd_q[free_idx]    <= sched.dis_pdst;
                    imm_q[free_idx]   <= sched.dis_imm;
                end
            end
        end
    end

    always_comb begin
        sched.idu_idu_rf_pipe2_vld       = 1'b0;
        sched.idu_idu_rf_pipe2_iid       = '0;
        sched.idu_idu_rf_pipe2_opcode    = '0;
        sched.idu_idu_rf_pipe2_funct7    = '0;
        sched.idu_idu_rf_pipe2_funct3    = '0;
        sched.idu_idu_rf_pipe2_pc        = '0;
        sched.idu_idu_rf_pipe2_psrc1_vld = 1'b0;
        sched.idu_idu_rf_pipe2_psrc1     = '0;
        sched.idu_idu_rf_pipe2_psrc2_vld = 1'b0;
        sched.idu_idu_rf_pipe2_psrc2     = '0;
        sched.idu_idu_rf_pipe2_pdst_vld  = 1'b0;
        sched.idu_idu_rf_pipe2_pdst      = '0;
        sched.idu_idu_rf_pipe2_imm_vld   = 1'b0;
        sched.idu_idu_rf_pipe2_imm       = '0;
        if (issue_go) begin
            sched.idu_idu_rf_pipe2_vld       = 1'b1;
            sched.idu_idu_rf_pipe2_iid       = iid_q[sel_idx];
            sched.idu_idu_rf_pipe2_opcode    = opc_q[sel_idx];
            sched.idu_idu_rf_pipe2_funct7    = f7_q[sel_idx];
            sched.idu_idu_rf_pipe2_funct3    = f3_q[sel_idx];
            sched.idu_idu_rf_pipe2_pc        = pc_q[sel_idx];
            sched.idu_idu_rf_pipe2_psrc1_vld = s1v_q[sel_idx];
            sched.idu_idu_rf_pipe2_psrc1     = s1_q[sel_idx];
            sched.idu_idu_rf_pipe2_psrc2_vld = s2v_q[sel_idx];
            sched.idu_idu_rf_pipe2_psrc2     = s2_q[sel_idx];
            sched.idu_idu_rf_pipe2_pdst_vld  = pdv_q[sel_idx];
            sched.idu_idu_rf_pipe2_pdst      = pd_q[sel_idx];
            sched.idu_idu_rf_pipe2_imm_vld   = immv_q[sel_idx];
            sched.idu_idu_rf_pipe2_imm       = imm_q[sel_idx];
        end else if (bypass_go) begin
            sched.idu_idu_rf_pipe2_vld       = 1'b1;
            sched.idu_idu_rf_pipe2_iid       = sched.dis_iid;
            sched.idu_idu_rf_pipe2_opcode    = sched.dis_opcode;
            sched.idu_idu_rf_pipe2_funct7    = sched.dis_funct7;
            sched.idu_idu_rf_pipe2_funct3    = sched.dis_funct3;
            sched.idu_idu_rf_pipe2_pc        = sched.dis_pc;
            sched.idu_idu_rf_pipe2_psrc1_vld = sched.dis_psrc1_vld;
            sched.idu_idu_rf_pipe2_psrc1     = sched.dis_psrc1;
            sched.idu_idu_rf_pipe2_psrc2_vld = sched.dis_psrc2_vld;
            sched.idu_idu_rf_pipe2_psrc2     = sched.dis_psrc2;
            sched.idu_idu_rf_pipe2_pdst_vld  = sched.dis_pdst_vld;
            sched.idu_idu_rf_pipe2_pdst      = sched.dis_pdst;
            sched.idu_idu_rf_pipe2_imm_vld   = sched.dis_imm_vld;
            sched.idu_idu_rf_pipe2_imm       = sched.dis_imm;
        end
    end
endmodule
